pe_issue_ctrl: RTL and testbench

Issue controller for the 16-input multi-precision PE pipeline (FP16/FP32/FP64 dot-product lanes). It accepts dot-product jobs, drives the pipeline mode select and per-beat issue strobe, and gates issue on operand availability and downstream result-buffer credits. It drains the pipeline before any precision change so that no two modes are ever in flight together. It also tags each result emerging at the pipeline output with valid/last.

---
 rtl/pe_ctrl_pkg.sv | 21 ++
 rtl/pe_inflight_tracker.sv | 36 +++
 rtl/pe_issue_ctrl.sv | 128 ++++++++++++
 tb/tb_pe_issue_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_ctrl_pkg.sv
// pe_ctrl_pkg: shared mode and FSM state types for the PE issue controller
package pe_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_FP16 = 2'b00,
        MODE_FP32 = 2'b01,
        MODE_FP64 = 2'b10,
        MODE_IDLE = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_ISSUE
    } state_e;

    function automatic logic mode_ok(input logic [1:0] m);
        return m != MODE_IDLE;
    endfunction

endpackage

// File: rtl/pe_inflight_tracker.sv
// pe_inflight_tracker: DEPTH-stage {valid,last} shadow of the PE pipeline
module pe_inflight_tracker #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  logic in_last,
    output logic out_valid,
    output logic out_last,
    output logic any_valid
);

    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] lst;

    // shift issued beats along in lockstep with the datapath; last is only kept for live beats
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
            lst <= '0;
        end else begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                vld[i] <= vld[i-1];
                lst[i] <= lst[i-1];
            end
            vld[0] <= in_valid;
            lst[0] <= in_valid && in_last;
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_last  = lst[DEPTH-1];
    assign any_valid = |vld;

endmodule

// File: rtl/pe_issue_ctrl.sv
// pe_issue_ctrl: job issue, precision-change drain and credit gating for the PE pipeline
module pe_issue_ctrl
    import pe_ctrl_pkg::*;
#(
    parameter int PIPE_LAT = 4,
    parameter int LEN_W    = 8,
    parameter int CREDITS  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [1:0]       job_mode,
    input  logic [LEN_W-1:0] job_len,
    input  logic             op_valid,
    output logic             op_ready,
    output logic [1:0]       pe_mode_sel,
    output logic             pe_issue,
    output logic             pe_last,
    output logic             res_valid,
    output logic             res_last,
    input  logic             credit_return,
    output logic             busy,
    output logic             err
);

    localparam int CREDIT_W = $clog2(CREDITS + 1);
    localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(CREDITS);

    state_e              state;
    state_e              state_nxt;
    logic [1:0]          mode_q;
    logic [LEN_W-1:0]    rem;
    logic [CREDIT_W-1:0] credit_cnt;
    logic                inflight;
    logic                accept;
    logic                credit_ovf;

    assign job_ready  = state == ST_IDLE;
    assign accept     = job_ready && job_valid;
    assign op_ready   = pe_issue;
    assign busy       = state != ST_IDLE || inflight;
    assign credit_ovf = credit_return && !pe_issue && credit_cnt == CREDIT_MAX;

    // next state and per-beat issue strobe; a mode change waits for an empty pipe
    always_comb begin
        state_nxt = state;
        pe_issue  = 1'b0;
        pe_last   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (job_valid && mode_ok(job_mode))
                    state_nxt = (job_mode == pe_mode_sel || !inflight) ? ST_ISSUE : ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!inflight)
                    state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                pe_issue = op_valid && credit_cnt != '0;
                pe_last  = pe_issue && rem == '0;
                if (pe_last)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // latch the accepted job and count down its beats as they issue
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= MODE_IDLE;
            rem    <= '0;
        end else if (accept && mode_ok(job_mode)) begin
            mode_q <= job_mode;
            rem    <= job_len;
        end else if (pe_issue) begin
            rem <= rem - 1'b1;
        end
    end

    // mode select changes only when entering ISSUE, and holds through IDLE
    always_ff @(posedge clk) begin
        if (rst)
            pe_mode_sel <= MODE_IDLE;
        else if (state_nxt == ST_ISSUE && state != ST_ISSUE)
            pe_mode_sel <= (state == ST_IDLE) ? job_mode : mode_q;
    end

    // downstream credits: issue consumes, return refunds, saturating at full
    always_ff @(posedge clk) begin
        if (rst)
            credit_cnt <= CREDIT_MAX;
        else if (pe_issue && !credit_return)
            credit_cnt <= credit_cnt - 1'b1;
        else if (credit_return && !pe_issue && credit_cnt != CREDIT_MAX)
            credit_cnt <= credit_cnt + 1'b1;
    end

    // sticky error for reserved-mode jobs and credit overflow
    always_ff @(posedge clk) begin
        if (rst)
            err <= 1'b0;
        else if ((accept && !mode_ok(job_mode)) || credit_ovf)
            err <= 1'b1;
    end

    pe_inflight_tracker #(
        .DEPTH(PIPE_LAT)
    ) u_tracker (
        .clk      (clk),
        .rst      (rst),
        .in_valid (pe_issue),
        .in_last  (pe_last),
        .out_valid(res_valid),
        .out_last (res_last),
        .any_valid(inflight)
    );

endmodule

// File: tb/tb_pe_issue_ctrl.sv
// tb_pe_issue_ctrl: directed and random stimulus against a queue-based reference model
module tb_pe_issue_ctrl;

    localparam int PIPE_LAT = 4;
    localparam int LEN_W    = 8;
    localparam int CREDITS  = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             job_valid;
    logic             job_ready;
    logic [1:0]       job_mode;
    logic [LEN_W-1:0] job_len;
    logic             op_valid;
    logic             op_ready;
    logic [1:0]       pe_mode_sel;
    logic             pe_issue;
    logic             pe_last;
    logic             res_valid;
    logic             res_last;
    logic             credit_return;
    logic             busy;
    logic             err;

    pe_issue_ctrl #(
        .PIPE_LAT(PIPE_LAT),
        .LEN_W   (LEN_W),
        .CREDITS (CREDITS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .job_valid    (job_valid),
        .job_ready    (job_ready),
        .job_mode     (job_mode),
        .job_len      (job_len),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .pe_mode_sel  (pe_mode_sel),
        .pe_issue     (pe_issue),
        .pe_last      (pe_last),
        .res_valid    (res_valid),
        .res_last     (res_last),
        .credit_return(credit_return),
        .busy         (busy),
        .err          (err)
    );

    always #5 clk = ~clk;

    // reference model: 0 idle, 1 waiting for empty pipe, 2 issuing
    int         phase;
    int         m_rem;
    int         m_credits;
    logic [1:0] m_mode;
    logic [1:0] m_sel;
    bit         m_err;
    int         due_q[$];
    bit         last_q[$];
    int         cyc;
    int         n_checks;
    int         n_fail;
    int         n_iss;
    int         n_rv;
    int         last_rv_cyc;
    int         first_fp64_cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        phase     = 0;
        m_rem     = 0;
        m_credits = CREDITS;
        m_mode    = 2'b11;
        m_sel     = 2'b11;
        m_err     = 1'b0;
        due_q.delete();
        last_q.delete();
    endtask

    task automatic step(input bit rs, input bit jv, input logic [1:0] jm, input int jl,
                        input bit ov, input bit cr);
        bit inflight;
        bit e_iss;
        bit e_last;
        bit e_rv;
        bit e_rl;
        rst           = rs;
        job_valid     = jv;
        job_mode      = jm;
        job_len       = LEN_W'(jl);
        op_valid      = ov;
        credit_return = cr;
        #2;
        while (due_q.size() > 0 && due_q[0] < cyc) begin
            void'(due_q.pop_front());
            void'(last_q.pop_front());
        end
        inflight = due_q.size() > 0;
        e_rv     = due_q.size() > 0 && due_q[0] == cyc;
        e_rl     = e_rv && last_q[0];
        e_iss    = phase == 2 && ov && m_credits > 0;
        e_last   = e_iss && m_rem == 0;
        check("job_ready", job_ready, phase == 0);
        check("pe_issue", pe_issue, e_iss);
        check("op_ready", op_ready, e_iss);
        check("pe_last", pe_last, e_last);
        check("pe_mode_sel", pe_mode_sel, m_sel);
        check("res_valid", res_valid, e_rv);
        check("res_last", res_last, e_rl);
        check("busy", busy, phase != 0 || inflight);
        check("err", err, m_err);
        if (pe_issue) n_iss++;
        if (res_valid) begin
            n_rv++;
            if (pe_mode_sel == 2'b00) last_rv_cyc = cyc;
        end
        if (pe_issue && pe_mode_sel == 2'b10 && first_fp64_cyc < 0) first_fp64_cyc = cyc;
        if (rs) begin
            model_reset();
        end else begin
            if (e_iss) begin
                due_q.push_back(cyc + PIPE_LAT);
                last_q.push_back(e_last);
                m_credits--;
            end
            if (cr) begin
                if (m_credits == CREDITS) m_err = 1'b1;
                else m_credits++;
            end
            case (phase)
                0: if (jv) begin
                    if (jm == 2'b11) begin
                        m_err = 1'b1;
                    end else begin
                        m_rem  = jl;
                        m_mode = jm;
                        if (jm == m_sel || !inflight) begin
                            phase = 2;
                            m_sel = jm;
                        end else begin
                            phase = 1;
                        end
                    end
                end
                1: if (!inflight) begin
                    phase = 2;
                    m_sel = m_mode;
                end
                default: if (e_iss) begin
                    if (m_rem == 0) phase = 0;
                    else m_rem--;
                end
            endcase
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit ov);
        for (int i = 0; i < n; i++) step(0, 0, 2'b00, 0, ov, 0);
    endtask

    task automatic do_reset();
        step(1, 0, 2'b00, 0, 0, 0);
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        cyc            = 0;
        first_fp64_cyc = -1;
        last_rv_cyc    = -1;
        model_reset();
        rst = 1'b1; job_valid = 1'b0; job_mode = 2'b00; job_len = '0;
        op_valid = 1'b0; credit_return = 1'b0;
        @(posedge clk);
        #1;
        do_reset();
        idle(2, 0);

        // FP16, 4 beats, operands always present
        n_iss = 0; n_rv = 0;
        step(0, 1, 2'b00, 3, 1, 0);
        idle(4, 1);
        check("fp16_issue_count", n_iss, 4);
        idle(5, 0);
        check("fp16_result_count", n_rv, 4);

        // FP16 2 beats then FP64 straight away: drain before switching mode
        do_reset();
        step(0, 1, 2'b00, 1, 1, 0);
        for (int i = 0; i < 12; i++) step(0, 1, 2'b10, 0, 1, 0);
        idle(6, 0);
        check("drain_gap", first_fp64_cyc - last_rv_cyc, 2);

        // credit exhaustion and per-pulse release
        do_reset();
        n_iss = 0;
        step(0, 1, 2'b01, 11, 1, 0);
        idle(15, 1);
        check("credit_stall", n_iss, CREDITS);
        for (int p = 0; p < 2; p++) begin
            step(0, 0, 2'b00, 0, 1, 1);
            idle(3, 1);
        end
        check("credit_release", n_iss, CREDITS + 2);

        // op_valid toggling
        do_reset();
        n_iss = 0;
        step(0, 1, 2'b10, 3, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 2'b00, 0, (i % 2) == 0, 0);
        check("toggle_issue_count", n_iss, 4);
        check("toggle_back_idle", job_ready, 1'b1);

        // reserved mode is dropped and flagged
        do_reset();
        step(0, 1, 2'b11, 2, 1, 0);
        check("rsv_err", err, 1'b1);
        check("rsv_stay_idle", job_ready, 1'b1);
        idle(2, 1);

        // credit return at full saturates and flags
        do_reset();
        n_iss = 0;
        step(0, 0, 2'b00, 0, 0, 1);
        check("ovf_err", err, 1'b1);
        step(0, 1, 2'b00, 9, 1, 0);
        idle(12, 1);
        check("ovf_saturated", n_iss, CREDITS);

        // reset mid-job with beats in flight
        do_reset();
        step(0, 1, 2'b00, 9, 1, 0);
        idle(3, 1);
        step(1, 0, 2'b00, 0, 1, 0);
        check("rst_mode_sel", pe_mode_sel, 2'b11);
        check("rst_busy", busy, 1'b0);
        n_rv = 0;
        idle(8, 0);
        check("rst_no_result", n_rv, 0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            bit         rs;
            bit         cr;
            logic [1:0] jm;
            rs = $urandom_range(0, 149) == 0;
            jm = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            cr = (m_credits < CREDITS && $urandom_range(0, 9) < 4) || $urandom_range(0, 299) == 0;
            step(rs, $urandom_range(0, 2) == 0, jm, $urandom_range(0, 5),
                 $urandom_range(0, 9) < 7, cr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
